dcache_port_arb: RTL

- Shares the single data-cache request port between two requesters:
  - committed-store drain from the store queue;
  - load issue from the load queue.
- Sequences one outstanding dcache transaction at a time: grant, request handshake, wait for response.
- Returns load data to the load queue with its tag.
- Broadcasts store completion so loads sleeping on a partial-overlap store can be woken.
- Sits between the STQ/LDQ fire interfaces and the dcache.

---
 rtl/dcache_port_arb.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dcache_port_arb.sv
// Arbitrates the single dcache port between store drain and load issue,
// keeping one transaction in flight and returning load data / store completions.
module dcache_port_arb #(
  parameter int XLEN          = 32,
  parameter int STQ_WIDTH     = 3,
  parameter int LDQ_WIDTH     = 3,
  parameter int ST_STARVE_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pipe_flush,
  input  logic                 st_req_valid,
  output logic                 st_req_ready,
  input  logic [XLEN-1:0]      st_req_addr,
  input  logic [XLEN-1:0]      st_req_data,
  input  logic [2:0]           st_req_size,
  input  logic [STQ_WIDTH-1:0] st_req_stq_tag,
  input  logic                 st_drain_urgent,
  input  logic                 ld_req_valid,
  output logic                 ld_req_ready,
  input  logic [XLEN-1:0]      ld_req_addr,
  input  logic [2:0]           ld_req_size,
  input  logic [LDQ_WIDTH-1:0] ld_req_ldq_tag,
  output logic                 dc_req_valid,
  input  logic                 dc_req_ready,
  output logic                 dc_req_wr,
  output logic [XLEN-1:0]      dc_req_addr,
  output logic [XLEN-1:0]      dc_req_data,
  output logic [2:0]           dc_req_size,
  input  logic                 dc_resp_valid,
  input  logic [XLEN-1:0]      dc_resp_data,
  output logic                 ld_resp_valid,
  output logic [XLEN-1:0]      ld_resp_data,
  output logic [LDQ_WIDTH-1:0] ld_resp_ldq_tag,
  output logic                 st_done_valid,
  output logic [STQ_WIDTH-1:0] st_done_stq_tag
);

  localparam int CNT_W = $clog2(ST_STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       starve_cnt;
  logic                   kill;
  logic                   r_wr;
  logic [XLEN-1:0]        r_addr;
  logic [XLEN-1:0]        r_data;
  logic [2:0]             r_size;
  logic [STQ_WIDTH-1:0]   r_stq_tag;
  logic [LDQ_WIDTH-1:0]   r_ldq_tag;
  logic                   st_win;
  logic                   st_grant;
  logic                   ld_grant;
  logic                   resp_fire;
  logic                   starved;

  always_comb begin
    starved   = (starve_cnt == CNT_W'(ST_STARVE_MAX));
    st_win    = st_req_valid && (!ld_req_valid || st_drain_urgent || starved);
    st_grant  = (state == IDLE) && st_win;
    // A flushed load still wins arbitration but is refused; the store waits.
    ld_grant  = (state == IDLE) && ld_req_valid && !st_win && !pipe_flush;
    resp_fire = (state == WAIT) && dc_resp_valid;
    state_nxt = state;
    unique case (state)
      IDLE:    if (st_grant || ld_grant) state_nxt = REQ;
      REQ:     if (dc_req_ready) state_nxt = WAIT;
      WAIT:    if (dc_resp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign st_req_ready = st_grant;
  assign ld_req_ready = ld_grant;
  assign dc_req_valid = (state == REQ);
  assign dc_req_wr    = r_wr;
  assign dc_req_addr  = r_addr;
  assign dc_req_data  = r_data;
  assign dc_req_size  = r_size;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      starve_cnt      <= '0;
      kill            <= 1'b0;
      r_wr            <= 1'b0;
      r_addr          <= '0;
      r_data          <= '0;
      r_size          <= '0;
      r_stq_tag       <= '0;
      r_ldq_tag       <= '0;
      ld_resp_valid   <= 1'b0;
      ld_resp_data    <= '0;
      ld_resp_ldq_tag <= '0;
      st_done_valid   <= 1'b0;
      st_done_stq_tag <= '0;
    end else begin
      state <= state_nxt;

      if (st_grant) begin
        r_wr      <= 1'b1;
        r_addr    <= st_req_addr;
        r_data    <= st_req_data;
        r_size    <= st_req_size;
        r_stq_tag <= st_req_stq_tag;
      end else if (ld_grant) begin
        r_wr      <= 1'b0;
        r_addr    <= ld_req_addr;
        r_data    <= '0;
        r_size    <= ld_req_size;
        r_ldq_tag <= ld_req_ldq_tag;
      end

      if (st_grant)
        starve_cnt <= '0;
      else if (ld_grant && st_req_valid && !starved)
        starve_cnt <= starve_cnt + CNT_W'(1);

      // Loads already on the port cannot be recalled; remember to drop the data.
      if (state == IDLE || resp_fire)
        kill <= 1'b0;
      else if (pipe_flush && !r_wr)
        kill <= 1'b1;

      st_done_valid <= resp_fire && r_wr;
      if (resp_fire && r_wr)
        st_done_stq_tag <= r_stq_tag;

      ld_resp_valid <= resp_fire && !r_wr && !kill && !pipe_flush;
      if (resp_fire && !r_wr) begin
        ld_resp_data    <= dc_resp_data;
        ld_resp_ldq_tag <= r_ldq_tag;
      end
    end
  end

endmodule
